// File: rtl/playrec_pkg.sv
// Shared definitions for the record/playback SDRAM paths: bus widths and
// the playback FSM state encoding.
package playrec_pkg;
   localparam int ADDR_W   = 23;
   localparam int SAMPLE_W = 32;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_PAUSE = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_ABORT = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      PS_IDLE  = ST_IDLE,
      PS_RUN   = ST_RUN,
      PS_PAUSE = ST_PAUSE,
      PS_DRAIN = ST_DRAIN,
      PS_ABORT = ST_ABORT,
      PS_DONE  = ST_DONE
   } play_state_t;
endpackage

// File: rtl/play_core_if.sv
// Bundle of the playback engine's control, SDRAM-port and audio-stream signals.
interface play_core_if;
   import playrec_pkg::*;

   logic                play_start;
   logic [ADDR_W-1:0]   play_start_addr;
   logic [ADDR_W-1:0]   play_end_addr;
   logic                play_pause;
   logic                play_stop;
   logic                play_done;
   logic                play_read;
   logic                play_write;
   logic [ADDR_W-1:0]   play_addr;
   logic [SAMPLE_W-1:0] play_writedata;
   logic [SAMPLE_W-1:0] play_readdata;
   logic                play_sdram_finished;
   logic [SAMPLE_W-1:0] play_audio_data;
   logic                play_audio_valid;
   logic                play_audio_ready;

   modport master (
      output play_start, play_start_addr, play_end_addr, play_pause, play_stop,
      output play_readdata, play_sdram_finished, play_audio_ready,
      input  play_done, play_read, play_write, play_addr, play_writedata,
      input  play_audio_data, play_audio_valid
   );

   modport slave (
      input  play_start, play_start_addr, play_end_addr, play_pause, play_stop,
      input  play_readdata, play_sdram_finished, play_audio_ready,
      output play_done, play_read, play_write, play_addr, play_writedata,
      output play_audio_data, play_audio_valid
   );
endinterface

// File: rtl/play_fifo.sv
// Synchronous prefetch FIFO; storage is not reset, only pointers and count.
module play_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [AW:0]       cnt_q;

   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign rdata_o = mem_q[rd_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end
endmodule

// File: rtl/play_core.sv
// Playback engine: fetches an SDRAM word range one read at a time into a
// prefetch FIFO and streams it to the DAC over a valid/ready handshake.
module play_core
   import playrec_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   play_core_if.slave bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [2:0]          state_q, state_d;
   logic [ADDR_W:0]     addr_q, addr_d, end_q, end_d;
   logic                exh_q, exh_d;
   logic                read_q, read_d;
   logic                rd_done, push, push_ok, pop, flush;
   logic                fifo_full, fifo_empty, audio_valid;
   logic [CNT_W-1:0]    fifo_cnt, cnt_d;
   logic [SAMPLE_W-1:0] fifo_head;

   assign rd_done     = read_q & bus.play_sdram_finished;
   assign push        = rd_done & (state_q != ST_ABORT);
   assign push_ok     = push & (~fifo_full | pop);
   assign flush       = state_q == ST_ABORT;
   assign audio_valid = ~fifo_empty & ((state_q == ST_RUN) | (state_q == ST_DRAIN));
   assign pop         = audio_valid & bus.play_audio_ready;
   // Occupancy after this edge; an issued read reserves one more slot.
   assign cnt_d       = fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);

   play_fifo #(.DATA_W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .flush_i (flush),
      .push_i  (push_ok),
      .wdata_i (bus.play_readdata),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      end_d   = end_q;
      exh_d   = exh_q;
      if (rd_done) begin
         addr_d = addr_q + (ADDR_W+1)'(1);
         if (addr_q == end_q) exh_d = 1'b1;
      end
      case (state_q)
         ST_IDLE: if (bus.play_start) begin
            addr_d  = {1'b0, bus.play_start_addr};
            end_d   = {1'b0, bus.play_end_addr};
            exh_d   = 1'b0;
            state_d = (bus.play_start_addr > bus.play_end_addr) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (bus.play_stop)       state_d = ST_ABORT;
            else if (bus.play_pause) state_d = ST_PAUSE;
            else if (exh_d)          state_d = ST_DRAIN;
         end
         ST_PAUSE: begin
            if (bus.play_stop)        state_d = ST_ABORT;
            else if (!bus.play_pause) state_d = exh_d ? ST_DRAIN : ST_RUN;
         end
         ST_DRAIN: begin
            if (bus.play_stop)       state_d = ST_ABORT;
            else if (bus.play_pause) state_d = ST_PAUSE;
            else if (cnt_d == '0)    state_d = ST_DONE;
         end
         // Wait out the in-flight read; its data is dropped by the push gate.
         ST_ABORT: if (!read_q || bus.play_sdram_finished) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      read_d = 1'b0;
      if (read_q && !bus.play_sdram_finished) read_d = 1'b1;
      else if (state_d == ST_RUN && !exh_d && cnt_d < DEPTH_C) read_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         end_q   <= '0;
         exh_q   <= 1'b0;
         read_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         end_q   <= end_d;
         exh_q   <= exh_d;
         read_q  <= read_d;
      end
   end

   assign bus.play_read        = read_q;
   assign bus.play_write       = 1'b0;
   assign bus.play_addr        = addr_q[ADDR_W-1:0];
   assign bus.play_writedata   = '0;
   assign bus.play_done        = state_q == ST_DONE;
   assign bus.play_audio_valid = audio_valid;
   assign bus.play_audio_data  = audio_valid ? fifo_head : '0;
endmodule

// File: tb/tb_play_core.sv
// Randomized bench for play_core: SDRAM responder, DAC sink and a range model.
module tb_play_core;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   play_core_if bus ();

   play_core #(.FIFO_DEPTH(DEPTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int lat = 3;
   bit lat_rand = 1'b0;
   int rdy_mode = 0;
   logic [22:0] rd_log[$];
   logic [31:0] got[$];
   int done_cnt = 0;
   int addr_glitch = 0;
   int stab_err = 0;

   function automatic logic [31:0] memval(input logic [22:0] a);
      return 32'h90 + {9'd0, a};
   endfunction

   // SDRAM: answers each read after a latency with one finished strobe.
   initial begin : sdram
      int cnt;
      int cur_lat;
      logic [22:0] a0;
      cnt = 0; cur_lat = 1; a0 = '0;
      bus.play_sdram_finished = 1'b0;
      bus.play_readdata = '0;
      forever begin
         @(posedge clk); #1;
         bus.play_sdram_finished = 1'b0;
         if (rst || !bus.play_read) cnt = 0;
         else begin
            if (cnt == 0) begin
               a0 = bus.play_addr;
               cur_lat = lat_rand ? int'($urandom_range(1, 5)) : lat;
            end
            cnt++;
            if (cnt >= cur_lat) begin
               if (bus.play_addr !== a0) addr_glitch++;
               bus.play_readdata = memval(bus.play_addr);
               bus.play_sdram_finished = 1'b1;
               rd_log.push_back(bus.play_addr);
               cnt = 0;
            end
         end
      end
   end

   initial begin : ready_drv
      bus.play_audio_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       bus.play_audio_ready = 1'b1;
            1:       bus.play_audio_ready = 1'b0;
            default: bus.play_audio_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : audio_sink
      logic hold_v;
      logic [31:0] hold_d;
      hold_v = 1'b0; hold_d = '0;
      forever begin
         @(negedge clk);
         if (rst) hold_v = 1'b0;
         else begin
            if (hold_v && bus.play_audio_valid && bus.play_audio_data !== hold_d) stab_err++;
            if (bus.play_audio_valid && bus.play_audio_ready) got.push_back(bus.play_audio_data);
            if (bus.play_done) done_cnt++;
            hold_v = bus.play_audio_valid && !bus.play_audio_ready;
            hold_d = bus.play_audio_data;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_play(input logic [22:0] s, input logic [22:0] e);
      @(posedge clk); #1;
      bus.play_start_addr = s;
      bus.play_end_addr = e;
      bus.play_start = 1'b1;
      @(posedge clk); #1;
      bus.play_start = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         cyc(1);
         if (bus.play_done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.play_read, bus.play_write, bus.play_done, bus.play_audio_valid} !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: read/write/done/valid=%b expected 0000",
                  {bus.play_read, bus.play_write, bus.play_done, bus.play_audio_valid});
      end
      vectors++;
      if (bus.play_addr !== 23'd0 || bus.play_audio_data !== 32'd0 || bus.play_writedata !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_data: addr=%h audio=%h wdata=%h expected all 0",
                  bus.play_addr, bus.play_audio_data, bus.play_writedata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int gb, rb, db, bad;
      bit ok;
      gb = got.size(); rb = rd_log.size(); db = done_cnt;
      lat = 3; lat_rand = 1'b0; rdy_mode = 0;
      start_play(23'h10, 23'h13);
      vectors++;
      if (bus.play_read !== 1'b1 || bus.play_addr !== 23'h10) begin
         miscompares++;
         $display("FAIL basic_first_read: read=%b addr=%h expected 1 and 000010", bus.play_read, bus.play_addr);
      end
      wait_done(200, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL basic_timeout: no done expected done within 200 cycles"); end
      cyc(1);
      bad = (got.size() - gb != 4) ? 1 : 0;
      if (bad == 0) for (int i = 0; i < 4; i++) if (got[gb+i] !== 32'hA0 + i) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL basic_samples: %0d bad, count %0d expected A0..A3 (4)", bad, got.size() - gb);
      end
      bad = (rd_log.size() - rb != 4) ? 1 : 0;
      if (bad == 0) for (int i = 0; i < 4; i++) if (rd_log[rb+i] !== 23'h10 + 23'(i)) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL basic_reads: %0d bad, count %0d expected 4 reads 0x10..0x13", bad, rd_log.size() - rb);
      end
      vectors++;
      if (done_cnt - db != 1 || bus.play_write !== 1'b0 || bus.play_writedata !== 32'd0) begin
         miscompares++;
         $display("FAIL basic_done: pulses=%0d write=%b expected 1 pulse, write 0", done_cnt - db, bus.play_write);
      end
   endtask

   task automatic test_backpressure();
      int gb, rb, bad;
      bit ok;
      gb = got.size(); rb = rd_log.size();
      lat_rand = 1'b1; rdy_mode = 1;
      start_play(23'h100, 23'h10F);
      cyc(100);
      vectors++;
      if (rd_log.size() - rb != DEPTH || bus.play_read !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_reads: reads=%0d read=%b expected %0d and 0", rd_log.size() - rb, bus.play_read, DEPTH);
      end
      vectors++;
      if (bus.play_audio_valid !== 1'b1 || bus.play_audio_data !== memval(23'h100)) begin
         miscompares++;
         $display("FAIL bp_head: valid=%b data=%h expected 1 %h", bus.play_audio_valid, bus.play_audio_data, memval(23'h100));
      end
      rdy_mode = 2;
      wait_done(600, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL bp_timeout: no done expected done within 600 cycles"); end
      cyc(1);
      bad = (got.size() - gb != 16 || rd_log.size() - rb != 16) ? 1 : 0;
      if (bad == 0) for (int i = 0; i < 16; i++)
         if (got[gb+i] !== memval(23'h100 + 23'(i)) || rd_log[rb+i] !== 23'h100 + 23'(i)) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL bp_stream: %0d bad, samples %0d reads %0d expected 16 in order", bad, got.size() - gb, rd_log.size() - rb);
      end
   endtask

   task automatic test_pause();
      int gb, rb, r0, g0, bad;
      bit ok, vbad;
      gb = got.size(); rb = rd_log.size();
      lat_rand = 1'b0; lat = 5; rdy_mode = 2;
      start_play(23'h200, 23'h20B);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (got.size() - gb >= 2 && bus.play_read && !bus.play_sdram_finished) begin ok = 1'b1; break; end
      end
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL pause_setup: no read in flight expected one within 300 cycles"); end
      r0 = rd_log.size() - rb;
      bus.play_pause = 1'b1;
      @(negedge clk);
      g0 = got.size();
      vbad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.play_audio_valid !== 1'b0) vbad = 1'b1;
      end
      vectors++;
      if (rd_log.size() - rb != r0 + 1 || bus.play_read !== 1'b0) begin
         miscompares++;
         $display("FAIL pause_reads: reads=%0d read=%b expected %0d and 0", rd_log.size() - rb, bus.play_read, r0 + 1);
      end
      vectors++;
      if (vbad || got.size() != g0) begin
         miscompares++;
         $display("FAIL pause_valid: valid seen=%b samples %0d expected valid 0 and %0d samples", vbad, got.size(), g0);
      end
      @(posedge clk); #1;
      bus.play_pause = 1'b0;
      wait_done(400, ok);
      cyc(1);
      bad = (!ok || got.size() - gb != 12) ? 1 : 0;
      if (bad == 0) for (int i = 0; i < 12; i++) if (got[gb+i] !== memval(23'h200 + 23'(i))) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL pause_resume: %0d bad, samples %0d expected 12 with no loss or duplicate", bad, got.size() - gb);
      end
   endtask

   task automatic test_stop();
      int gb, rb, db;
      bit ok, seen, dropped, vbad;
      gb = got.size(); rb = rd_log.size(); db = done_cnt;
      lat_rand = 1'b0; lat = 6; rdy_mode = 1;
      start_play(23'h300, 23'h30F);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rd_log.size() - rb == 2 && bus.play_read && !bus.play_sdram_finished) begin ok = 1'b1; break; end
      end
      bus.play_stop = 1'b1;
      seen = 1'b0; dropped = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.play_done) break;
         if (bus.play_sdram_finished) seen = 1'b1;
         else if (!seen && !bus.play_read) dropped = 1'b1;
      end
      vectors++;
      if (!ok || dropped || !seen) begin
         miscompares++;
         $display("FAIL stop_hold: setup=%b dropped=%b finished=%b expected 1 0 1", ok, dropped, seen);
      end
      vectors++;
      if (bus.play_done !== 1'b1 || rd_log.size() - rb != 3) begin
         miscompares++;
         $display("FAIL stop_done: done=%b reads=%0d expected 1 and 3", bus.play_done, rd_log.size() - rb);
      end
      @(posedge clk); #1;
      bus.play_stop = 1'b0;
      rdy_mode = 0;
      vbad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.play_audio_valid !== 1'b0 || bus.play_read !== 1'b0) vbad = 1'b1;
      end
      vectors++;
      if (vbad || got.size() != gb || done_cnt - db != 1) begin
         miscompares++;
         $display("FAIL stop_flush: activity=%b samples=%0d pulses=%0d expected 0 0 1", vbad, got.size() - gb, done_cnt - db);
      end
   endtask

   task automatic test_boundary();
      int gb, rb, db;
      bit ok, rbad;
      gb = got.size(); rb = rd_log.size(); db = done_cnt;
      lat = 3; rdy_mode = 0;
      start_play(23'h7FFFFF, 23'h7FFFFF);
      wait_done(100, ok);
      rbad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.play_read !== 1'b0) rbad = 1'b1;
      end
      vectors++;
      if (!ok || rbad || rd_log.size() - rb != 1 || rd_log[rb] !== 23'h7FFFFF) begin
         miscompares++;
         $display("FAIL top_reads: done=%b extra=%b reads=%0d expected 1 read at 7fffff, no wrap", ok, rbad, rd_log.size() - rb);
      end
      vectors++;
      if (got.size() - gb != 1 || got[gb] !== memval(23'h7FFFFF) || done_cnt - db != 1) begin
         miscompares++;
         $display("FAIL top_sample: samples=%0d pulses=%0d expected one sample %h and one pulse",
                  got.size() - gb, done_cnt - db, memval(23'h7FFFFF));
      end
      rb = rd_log.size(); db = done_cnt;
      start_play(23'd5, 23'd4);
      vectors++;
      if (bus.play_done !== 1'b1 || bus.play_read !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_range: done=%b read=%b expected 1 0 at N+1", bus.play_done, bus.play_read);
      end
      cyc(5);
      vectors++;
      if (rd_log.size() != rb || done_cnt - db != 1) begin
         miscompares++;
         $display("FAIL empty_range_after: reads=%0d pulses=%0d expected 0 and 1", rd_log.size() - rb, done_cnt - db);
      end
   endtask

   task automatic test_reset_midread();
      int gb, bad;
      bit ok;
      lat = 8; rdy_mode = 1;
      start_play(23'h400, 23'h40F);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.play_read && bus.play_audio_valid) begin ok = 1'b1; break; end
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (!ok || {bus.play_read, bus.play_done, bus.play_audio_valid} !== 3'b0 ||
          bus.play_addr !== 23'd0 || bus.play_audio_data !== 32'd0) begin
         miscompares++;
         $display("FAIL rst_mid: setup=%b read=%b valid=%b addr=%h data=%h expected all 0",
                  ok, bus.play_read, bus.play_audio_valid, bus.play_addr, bus.play_audio_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      gb = got.size();
      lat = 2; rdy_mode = 0;
      start_play(23'h20, 23'h22);
      wait_done(100, ok);
      cyc(1);
      bad = (!ok || got.size() - gb != 3) ? 1 : 0;
      if (bad == 0) for (int i = 0; i < 3; i++) if (got[gb+i] !== memval(23'h20 + 23'(i))) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL rst_restart: %0d bad, samples %0d expected 3 from 0x20", bad, got.size() - gb);
      end
   endtask

   task automatic test_random();
      int gb, rb, db, len, bad;
      logic [22:0] s;
      bit ok;
      lat_rand = 1'b1; rdy_mode = 2;
      for (int it = 0; it < 6; it++) begin
         gb = got.size(); rb = rd_log.size(); db = done_cnt;
         s = 23'($urandom_range(0, 32'h7FFF00));
         len = int'($urandom_range(1, 10));
         start_play(s, 23'(s + 23'(len - 1)));
         ok = 1'b0;
         for (int i = 0; i < 800; i++) begin
            cyc(1);
            bus.play_pause = ($urandom_range(0, 9) == 0);
            if (bus.play_done) begin ok = 1'b1; break; end
         end
         bus.play_pause = 1'b0;
         cyc(1);
         bad = (!ok || got.size() - gb != len || rd_log.size() - rb != len) ? 1 : 0;
         if (bad == 0) for (int i = 0; i < len; i++)
            if (got[gb+i] !== memval(23'(s + 23'(i))) || rd_log[rb+i] !== 23'(s + 23'(i))) bad++;
         vectors++;
         if (bad != 0) begin
            miscompares++;
            $display("FAIL rand_stream[%0d]: %0d bad, samples %0d reads %0d expected %0d from %h",
                     it, bad, got.size() - gb, rd_log.size() - rb, len, s);
         end
         vectors++;
         if (done_cnt - db != 1) begin
            miscompares++;
            $display("FAIL rand_done[%0d]: pulses=%0d expected 1", it, done_cnt - db);
         end
      end
      vectors++;
      if (stab_err != 0 || addr_glitch != 0) begin
         miscompares++;
         $display("FAIL handshake_stable: audio changes=%0d addr changes=%0d expected 0 0", stab_err, addr_glitch);
      end
   endtask

   initial begin
      bus.play_start = 1'b0;
      bus.play_start_addr = '0;
      bus.play_end_addr = '0;
      bus.play_pause = 1'b0;
      bus.play_stop = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_pause();
      test_stop();
      test_boundary();
      test_reset_midread();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
